// File: rtl/elevator_car_controller.sv
// Car-side elevator controller: latches floor requests, runs a SCAN scheduler,
// times travel and door dwell, and drives the per-floor light interface.
module elevator_car_controller #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floorbutton,
  output logic [1:0]            direction,
  output logic [NUM_FLOORS-1:0] floor,
  output logic [NUM_FLOORS-1:0] car_above,
  output logic [NUM_FLOORS-1:0] car_below,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1;
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES);
  localparam logic [DW-1:0] DOOR_ONE    = DW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR      = 2'b11
  } state_t;

  state_t                  state_r, state_nx;
  logic [FW-1:0]           cur_floor_r, cur_nx;
  logic [TW-1:0]           travel_r, travel_nx;
  logic [DW-1:0]           dwell_r, dwell_nx;
  logic                    last_up_r, last_up_nx;
  logic [NUM_FLOORS-1:0]   clr, pending_nx;
  logic [1:0]              dir_nx;

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] r;
    for (int i = 0; i < NUM_FLOORS; i++) r[i] = (i == int'(f));
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_of(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] r;
    for (int i = 0; i < NUM_FLOORS; i++) r[i] = (int'(f) > i);
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_of(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] r;
    for (int i = 0; i < NUM_FLOORS; i++) r[i] = (int'(f) < i);
    return r;
  endfunction

  // SCAN decision: stop here, keep the preferred direction, else reverse, else idle.
  function automatic state_t decide(input logic [FW-1:0] f,
                                    input logic [NUM_FLOORS-1:0] p,
                                    input logic up_pref);
    logic any_above;
    logic any_below;
    any_above = |(p & below_of(f));
    any_below = |(p & above_of(f));
    if (p[f])                                    return DOOR;
    else if (any_above && (up_pref || !any_below)) return MOVE_UP;
    else if (any_below)                          return MOVE_DOWN;
    else                                         return IDLE;
  endfunction

  // Next-state, counters, request latch and next output values.
  always_comb begin
    state_nx   = state_r;
    cur_nx     = cur_floor_r;
    travel_nx  = travel_r;
    dwell_nx   = dwell_r;
    last_up_nx = last_up_r;
    case (state_r)
      IDLE: begin
        state_nx = decide(cur_floor_r, pending_r_view(), last_up_r);
      end
      MOVE_UP: begin
        if (travel_r == TRAVEL_LAST) begin
          travel_nx = '0;
          cur_nx    = cur_floor_r + FW'(1);
          state_nx  = decide(cur_nx, pending, last_up_r);
        end else begin
          travel_nx = travel_r + TW'(1);
        end
      end
      MOVE_DOWN: begin
        if (travel_r == TRAVEL_LAST) begin
          travel_nx = '0;
          cur_nx    = cur_floor_r - FW'(1);
          state_nx  = decide(cur_nx, pending, last_up_r);
        end else begin
          travel_nx = travel_r + TW'(1);
        end
      end
      DOOR: begin
        if (floorbutton[cur_floor_r]) begin
          dwell_nx = DOOR_LOAD;
        end else if (dwell_r == DOOR_ONE) begin
          dwell_nx = '0;
          state_nx = decide(cur_floor_r, pending, last_up_r);
        end else begin
          dwell_nx = dwell_r - DW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (state_nx == DOOR && state_r != DOOR) begin
      dwell_nx = DOOR_LOAD;
    end else begin
      dwell_nx = dwell_nx;
    end

    if (state_nx == MOVE_UP) begin
      last_up_nx = 1'b1;
    end else if (state_nx == MOVE_DOWN) begin
      last_up_nx = 1'b0;
    end else begin
      last_up_nx = last_up_nx;
    end

    // The floor whose door is entered or held open never latches a request.
    if (state_nx == DOOR) begin
      clr = onehot(cur_nx);
    end else begin
      clr = '0;
    end
    pending_nx = (pending | floorbutton) & ~clr;

    case (state_nx)
      MOVE_UP:   dir_nx = 2'b10;
      MOVE_DOWN: dir_nx = 2'b01;
      default:   dir_nx = 2'b00;
    endcase
  end

  function automatic logic [NUM_FLOORS-1:0] pending_r_view();
    return pending;
  endfunction

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      cur_floor_r <= '0;
      travel_r    <= '0;
      dwell_r     <= '0;
      last_up_r   <= 1'b1;
      pending     <= '0;
      direction   <= 2'b00;
      door_open   <= 1'b0;
      floor       <= NUM_FLOORS'(1);
      car_above   <= '0;
      car_below   <= ~NUM_FLOORS'(1);
    end else begin
      state_r     <= state_nx;
      cur_floor_r <= cur_nx;
      travel_r    <= travel_nx;
      dwell_r     <= dwell_nx;
      last_up_r   <= last_up_nx;
      pending     <= pending_nx;
      direction   <= dir_nx;
      door_open   <= (state_nx == DOOR);
      floor       <= onehot(cur_nx);
      car_above   <= above_of(cur_nx);
      car_below   <= below_of(cur_nx);
    end
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed self-checking bench for elevator_car_controller (4 floors, travel 4, dwell 3).
module tb_elevator_car_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] floorbutton;
  logic [1:0] direction;
  logic [3:0] floor;
  logic [3:0] car_above;
  logic [3:0] car_below;
  logic       door_open;
  logic [3:0] pending;

  int passed = 0;
  int total  = 0;

  elevator_car_controller #(.NUM_FLOORS(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .floorbutton(floorbutton), .direction(direction),
    .floor(floor), .car_above(car_above), .car_below(car_below),
    .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    floorbutton = 4'b1111;
    ticks(2);
    reset = 1'b1;
    floorbutton = 4'b0000;
  endtask

  initial begin
    int stops;
    logic prev_open;
    logic went_down;
    logic [3:0] stop_floor [0:3];

    // 1: reset state
    do_reset();
    chk("rst_floor", 8'(floor), 8'h01);
    chk("rst_above", 8'(car_above), 8'h00);
    chk("rst_below", 8'(car_below), 8'h0E);
    chk("rst_dir", 8'(direction), 8'h00);
    chk("rst_door", 8'(door_open), 8'h00);
    chk("rst_pending", 8'(pending), 8'h00);

    // 2: single request to floor 2
    floorbutton = 4'b0100;
    tick();
    floorbutton = 4'b0000;
    chk("t2_pend_e0", 8'(pending), 8'h04);
    chk("t2_dir_e0", 8'(direction), 8'h00);
    tick();
    chk("t2_dir_e1", 8'(direction), 8'h02);
    ticks(3);
    chk("t2_floor_e4", 8'(floor), 8'h01);
    tick();
    chk("t2_floor_e5", 8'(floor), 8'h02);
    chk("t2_above_e5", 8'(car_above), 8'h01);
    chk("t2_below_e5", 8'(car_below), 8'h0C);
    chk("t2_dir_e5", 8'(direction), 8'h02);
    ticks(4);
    chk("t2_floor_e9", 8'(floor), 8'h04);
    chk("t2_door_e9", 8'(door_open), 8'h01);
    chk("t2_pend_e9", 8'(pending), 8'h00);
    chk("t2_dir_e9", 8'(direction), 8'h00);
    ticks(2);
    chk("t2_door_e11", 8'(door_open), 8'h01);
    tick();
    chk("t2_door_e12", 8'(door_open), 8'h00);
    chk("t2_dir_e12", 8'(direction), 8'h00);
    tick();
    chk("t2_idle", 8'(direction), 8'h00);

    // 4: door held open at floor 2
    floorbutton = 4'b0100;
    tick();
    floorbutton = 4'b0000;
    chk("t4_pend_idle", 8'(pending), 8'h04);
    tick();
    chk("t4_door_enter", 8'(door_open), 8'h01);
    chk("t4_pend_enter", 8'(pending), 8'h00);
    floorbutton = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_door_hold", 8'(door_open), 8'h01);
      chk("t4_pend_hold", 8'(pending), 8'h00);
    end
    floorbutton = 4'b0000;
    tick();
    chk("t4_door_rel1", 8'(door_open), 8'h01);
    tick();
    chk("t4_door_rel2", 8'(door_open), 8'h01);
    tick();
    chk("t4_door_rel3", 8'(door_open), 8'h00);
    chk("t4_dir_rel3", 8'(direction), 8'h00);
    chk("t4_pend_rel3", 8'(pending), 8'h00);

    // 5: reset mid-travel between floors 1 and 2
    do_reset();
    floorbutton = 4'b0100;
    tick();
    floorbutton = 4'b0000;
    ticks(5);
    chk("t5_floor_mid", 8'(floor), 8'h02);
    tick();
    chk("t5_dir_mid", 8'(direction), 8'h02);
    reset = 1'b0;
    floorbutton = 4'b1000;
    tick();
    reset = 1'b1;
    floorbutton = 4'b0000;
    chk("t5_floor", 8'(floor), 8'h01);
    chk("t5_dir", 8'(direction), 8'h00);
    chk("t5_pend", 8'(pending), 8'h00);
    chk("t5_door", 8'(door_open), 8'h00);

    // 3: going up to 3, floor 0 requested while passing floor 1
    floorbutton = 4'b1000;
    tick();
    floorbutton = 4'b0000;
    ticks(5);
    chk("t3_at1", 8'(floor), 8'h02);
    floorbutton = 4'b0001;
    tick();
    floorbutton = 4'b0000;
    chk("t3_pend_both", 8'(pending), 8'h09);
    for (int k = 0; k < 100 && door_open !== 1'b1; k++) tick();
    chk("t3_door3", 8'(door_open), 8'h01);
    chk("t3_floor3", 8'(floor), 8'h08);
    chk("t3_above3", 8'(car_above), 8'h07);
    for (int k = 0; k < 100 && direction === 2'b00; k++) tick();
    chk("t3_dir_down", 8'(direction), 8'h01);
    for (int k = 0; k < 100 && floor !== 4'b0010; k++) tick();
    chk("t3_above1", 8'(car_above), 8'h01);
    chk("t3_dir_at1", 8'(direction), 8'h01);
    for (int k = 0; k < 100 && door_open !== 1'b1; k++) tick();
    chk("t3_floor0", 8'(floor), 8'h01);
    chk("t3_above0", 8'(car_above), 8'h00);
    ticks(3);
    chk("t3_idle_dir", 8'(direction), 8'h00);
    chk("t3_idle_pend", 8'(pending), 8'h00);

    // 6: all buttons at once served in SCAN order
    do_reset();
    floorbutton = 4'b1111;
    tick();
    floorbutton = 4'b0000;
    chk("t6_pend_all", 8'(pending), 8'h0F);
    tick();
    chk("t6_door0", 8'(door_open), 8'h01);
    chk("t6_pend_after0", 8'(pending), 8'h0E);
    stops = 0;
    prev_open = 1'b1;
    went_down = 1'b0;
    for (int k = 0; k < 4; k++) stop_floor[k] = 4'b0000;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (door_open && !prev_open) begin
        if (stops < 4) stop_floor[stops] = floor;
        stops++;
      end
      if (direction == 2'b01) went_down = 1'b1;
      prev_open = door_open;
    end
    chk("t6_stops", 8'(stops), 8'd3);
    chk("t6_stop1", 8'(stop_floor[0]), 8'h02);
    chk("t6_stop2", 8'(stop_floor[1]), 8'h04);
    chk("t6_stop3", 8'(stop_floor[2]), 8'h08);
    chk("t6_no_down", 8'(went_down), 8'h00);
    chk("t6_pend_end", 8'(pending), 8'h00);
    chk("t6_floor_end", 8'(floor), 8'h08);
    chk("t6_dir_end", 8'(direction), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
